// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch-stage types: FSM state, queue entry layout and instruction size.
package fetch_pkg;
  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instruction;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Synchronous FIFO with flush; head is combinational from the read pointer.
// Push lands in one cycle; a flush wins over a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // The producer's credit scheme must never let a push hit a full queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(do_push && count == FULL_COUNT));
    end
  end
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues to a 1-cycle instruction RAM, queues {pc, instr} for decode.
// Request at T reaches decode at T+2; issue stops when queued + in-flight entries reach DEPTH.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  // Entry layout comes from fetch_pkg, so XLEN must equal FETCH_XLEN.
  parameter int              XLEN       = FETCH_XLEN,
  parameter int              DEPTH      = 4,
  parameter int              ADDR_WIDTH = 16,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_enable,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [XLEN-1:0]          dec_pc,
  output logic [XLEN-1:0]          dec_instruction,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     fetch_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            bad_pc;
  logic            issue;
  logic            pop;
  logic [CW:0]     pending;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  function automatic logic pc_illegal(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00) || (|pc[XLEN-1:ADDR_WIDTH]);
  endfunction

  assign bad_pc  = pc_illegal(fetch_pc);
  assign pending = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
  // A same-cycle pop is deliberately not credited.
  assign issue   = !rst && (state == RUN) && fetch_enable && !redirect_valid
                   && !bad_pc && (pending < CREDIT_LIMIT);
  assign pop     = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        state    <= pc_illegal(redirect_pc) ? FAULT : RUN;
      end else begin
        if (issue) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        if (state == RUN && bad_pc) state <= FAULT;
      end
    end
  end

  // A redirect flushes the queue, which also drops the response landing that cycle.
  assign push_entry = '{pc: inflight_pc, instruction: imem_rdata};

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (inflight),
    .data (push_entry),
    .pop  (pop),
    .head (head_entry),
    .count(occupancy)
  );

  assign imem_req        = issue;
  assign imem_addr       = fetch_pc;
  assign dec_valid       = occupancy != '0;
  assign dec_pc          = head_entry.pc;
  assign dec_instruction = head_entry.instruction;
  assign fetch_fault     = state == FAULT;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised and directed bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, fetch_enable, redirect_valid, dec_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, dec_valid, fetch_fault;
  logic [31:0] imem_addr, dec_pc, dec_instruction;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .ADDR_WIDTH(16), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_instruction(dec_instruction), .occupancy(occupancy), .fetch_fault(fetch_fault)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc, m_pend_pc, salt;
  bit          m_pend, m_fault;
  int          n_checks = 0;
  int          n_err = 0;

  logic        e_req, e_valid, e_fault;
  logic [31:0] e_addr, e_pc, e_instr;
  logic [2:0]  e_occ;

  function automatic logic illegal(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= 32'h0001_0000);
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  task automatic sample();
    @(negedge clk);
    e_req   = !rst && !m_fault && fetch_enable && !redirect_valid && !illegal(m_pc)
              && (m_q.size() + int'(m_pend)) < DEPTH;
    e_addr  = m_pc;
    e_valid = m_q.size() > 0;
    e_occ   = 3'(m_q.size());
    e_fault = m_fault;
    e_pc    = e_valid ? m_q[0].pc : 32'h0;
    e_instr = e_valid ? m_q[0].instr : 32'h0;
  endtask

  task automatic advance();
    bit          req;
    logic [31:0] addr;
    req  = e_req;
    addr = m_pc;
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_fault = 0; m_pend = 0; m_q.delete();
    end else begin
      if (m_q.size() > 0 && dec_ready) void'(m_q.pop_front());
      if (redirect_valid) begin
        m_q.delete(); m_pend = 0; m_pc = redirect_pc; m_fault = illegal(redirect_pc);
      end else begin
        if (m_pend) m_q.push_back('{m_pend_pc, imem_rdata});
        if (!m_fault && illegal(m_pc)) m_fault = 1;
        m_pend = req;
        if (req) begin m_pend_pc = m_pc; m_pc = m_pc + 32'd4; end
      end
    end
    #1;
    imem_rdata = req ? instr_of(addr) : $urandom();
  endtask

  task automatic do_reset();
    rst = 1; redirect_valid = 0; fetch_enable = 1; dec_ready = 1;
    repeat (2) begin sample(); advance(); end
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; fetch_enable = 1; redirect_valid = 0; dec_ready = 1;
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req_first got=%b exp=0", imem_req); end
    advance();
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_checks++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
    n_checks++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    advance();
    rst = 0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      sample();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        n_err++; $display("FAIL stream_req i=%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
      n_checks++; if (dec_valid !== (i >= 2)) begin
        n_err++; $display("FAIL stream_valid i=%0d got=%b exp=%b", i, dec_valid, i >= 2); end
      if (i >= 2) begin
        n_checks++; if (dec_pc !== 32'(4 * (i - 2)) || dec_instruction !== instr_of(32'(4 * (i - 2)))) begin
          n_err++; $display("FAIL stream_head i=%0d got=%h/%h exp=%h", i, dec_pc, dec_instruction, 32'(4 * (i - 2))); end
      end
      n_checks++; if (occupancy > 3'd2) begin n_err++; $display("FAIL stream_occ i=%0d got=%0d exp<=2", i, occupancy); end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int          nreq;
    logic [31:0] got[$];
    logic [31:0] resume;
    do_reset();
    dec_ready = 0; nreq = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_req === 1'b1) nreq++;
      advance();
    end
    sample();
    n_checks++; if (nreq != DEPTH) begin n_err++; $display("FAIL bp_nreq got=%0d exp=%0d", nreq, DEPTH); end
    n_checks++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_occ got=%0d exp=4", occupancy); end
    n_checks++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req got=%b exp=0", imem_req); end
    advance();
    dec_ready = 1; resume = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (dec_valid === 1'b1) got.push_back(dec_pc);
      if (imem_req === 1'b1 && resume == 32'hFFFF_FFFF) resume = imem_addr;
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (got.size() <= k || got[k] !== 32'(4 * k)) begin
        n_err++; $display("FAIL bp_drain k=%0d got=%h exp=%h", k, (got.size() > k) ? got[k] : 32'hx, 32'(4 * k)); end
    end
    n_checks++; if (resume !== 32'd16) begin n_err++; $display("FAIL bp_resume got=%h exp=10", resume); end
  endtask

  task automatic test_redirect();
    do_reset();
    dec_ready = 0;
    repeat (4) begin sample(); advance(); end
    redirect_valid = 1; redirect_pc = 32'h100;
    sample();
    n_checks++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL rd_pre_occ got=%0d exp=3", occupancy); end
    n_checks++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req got=%b exp=0", imem_req); end
    advance();
    redirect_valid = 0;
    sample();
    n_checks++; if (occupancy !== 3'd0 || dec_valid !== 1'b0) begin
      n_err++; $display("FAIL rd_flush got=%0d/%b exp=0/0", occupancy, dec_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL rd_target got=%b/%h exp=1/100", imem_req, imem_addr); end
    advance();
    sample();
    n_checks++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rd_stale got=%0d exp=0", occupancy); end
    advance();
    sample();
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instruction !== instr_of(32'h100)) begin
      n_err++; $display("FAIL rd_head got=%b/%h/%h exp=1/100", dec_valid, dec_pc, dec_instruction); end
    advance();
  endtask

  task automatic test_redirect_pop();
    logic [31:0] got[$];
    logic [31:0] exp_pcs[7];
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'h300, 32'h304, 32'h308, 32'h30c};
    do_reset();
    dec_ready = 1;
    for (int i = 0; i < 11; i++) begin
      redirect_valid = (i == 4); redirect_pc = 32'h300;
      sample();
      if (dec_valid === 1'b1) got.push_back(dec_pc);
      if (i == 5) begin
        n_checks++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rp_occ got=%0d exp=0", occupancy); end
      end
      advance();
    end
    redirect_valid = 0;
    n_checks++; if (got.size() != 7) begin n_err++; $display("FAIL rp_count got=%0d exp=7", got.size()); end
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (got.size() <= k || got[k] !== exp_pcs[k]) begin
        n_err++; $display("FAIL rp_pc k=%0d got=%h exp=%h", k, (got.size() > k) ? got[k] : 32'hx, exp_pcs[k]); end
    end
  endtask

  task automatic test_fault();
    int nreq;
    do_reset();
    redirect_valid = 1; redirect_pc = 32'h102;
    sample(); advance();
    redirect_valid = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      n_checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || occupancy !== 3'd0) begin
        n_err++; $display("FAIL ft_mis i=%0d got=%b/%b/%0d exp=1/0/0", i, fetch_fault, imem_req, occupancy); end
      advance();
    end
    redirect_valid = 1; redirect_pc = 32'h200;
    sample(); advance();
    redirect_valid = 0;
    sample();
    n_checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_err++; $display("FAIL ft_clear got=%b/%b/%h exp=0/1/200", fetch_fault, imem_req, imem_addr); end
    advance();
    redirect_valid = 1; redirect_pc = 32'hFFF0;
    sample(); advance();
    redirect_valid = 0; nreq = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_req === 1'b1) nreq++;
      n_checks++; if ((imem_req === 1'b1) && (imem_addr >= 32'h1_0000)) begin
        n_err++; $display("FAIL ft_range_req i=%0d got=%h exp<10000", i, imem_addr); end
      advance();
    end
    sample();
    n_checks++; if (nreq != 4) begin n_err++; $display("FAIL ft_nreq got=%0d exp=4", nreq); end
    n_checks++; if (fetch_fault !== 1'b1 || imem_addr !== 32'h1_0000) begin
      n_err++; $display("FAIL ft_range got=%b/%h exp=1/10000", fetch_fault, imem_addr); end
    advance();
  endtask

  task automatic test_reset_mid();
    logic [31:0] got[$];
    do_reset();
    dec_ready = 0;
    repeat (4) begin sample(); advance(); end
    rst = 1; redirect_valid = 1; redirect_pc = 32'h400;
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req got=%b exp=0", imem_req); end
    advance();
    rst = 0; redirect_valid = 0;
    sample();
    n_checks++; if (occupancy !== 3'd0 || dec_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL rm_state got=%0d/%b/%h exp=0/0/%h", occupancy, dec_valid, imem_addr, RESET_PC); end
    advance();
    fetch_enable = 0; dec_ready = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin
        n_err++; $display("FAIL fe_hold i=%0d got=%b/%h exp=0/4", i, imem_req, imem_addr); end
      if (dec_valid === 1'b1) got.push_back(dec_pc);
      advance();
    end
    fetch_enable = 1;
    n_checks++; if (got.size() != 1 || got[0] !== 32'h0) begin
      n_err++; $display("FAIL fe_drain got=%0d entries exp=1 entry pc 0", got.size()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst            = ($urandom % 150) == 0;
      fetch_enable   = ($urandom % 10) != 0;
      dec_ready      = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 14) == 0;
      case ($urandom % 8)
        0:       redirect_pc = {$urandom % 32'h4000, 2'b10};
        1:       redirect_pc = 32'h1_0000 + {$urandom % 32'h100, 2'b00};
        2:       redirect_pc = 32'hFFF8;
        default: redirect_pc = {16'h0, 14'($urandom), 2'b00};
      endcase
      sample();
      n_checks++; if (imem_req !== e_req) begin n_err++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
      n_checks++; if (imem_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, e_addr); end
      n_checks++; if (dec_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, dec_valid, e_valid); end
      n_checks++; if (occupancy !== e_occ) begin n_err++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy, e_occ); end
      n_checks++; if (fetch_fault !== e_fault) begin n_err++; $display("FAIL rnd_fault c=%0d got=%b exp=%b", c, fetch_fault, e_fault); end
      if (e_valid) begin
        n_checks++; if (dec_pc !== e_pc || dec_instruction !== e_instr) begin
          n_err++; $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, dec_pc, dec_instruction, e_pc, e_instr); end
      end
      advance();
    end
    rst = 0; redirect_valid = 0;
  endtask

  initial begin
    rst = 1; fetch_enable = 0; redirect_valid = 0; redirect_pc = 32'h0;
    dec_ready = 0; imem_rdata = 32'h0; salt = $urandom();
    m_pc = RESET_PC; m_pend_pc = 32'h0; m_pend = 0; m_fault = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_fault();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation instruction fetch stage. It owns the fetch PC and issues sequential requests to a fixed-1-cycle-latency instruction RAM. Returned instructions are buffered with their PCs in a DEPTH-entry queue and delivered to decode over a valid/ready handshake. Redirects (branch/jump/mispredict correction) flush the queue, discard the in-flight fetch, and can raise a fetch fault; this replaces the IF PC register/adder/stall logic of the current pipeline.

Parameters:
XLEN, 32, PC and instruction width
DEPTH, 4, queue entries; power of two, >=2; >=3 required for 1 instr/cycle sustained
ADDR_WIDTH, 16, byte-address bits backed by instruction RAM; PC >= 2**ADDR_WIDTH is a fault
RESET_PC, 0, fetch PC after reset (must be 4-byte aligned)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
fetch_enable  input  1  1 = fetch may issue; 0 = hold PC, issue nothing (debug halt)
redirect_valid  input  1  redirect request this cycle
redirect_pc  input  XLEN  redirect target
imem_req  output  1  read strobe to instruction RAM
imem_addr  output  XLEN  byte address of request (= fetch PC)
imem_rdata  input  XLEN  instruction, valid exactly 1 cycle after imem_req
dec_valid  output  1  queue head valid
dec_ready  input  1  decode accepts head (ID not stalled)
dec_pc  output  XLEN  PC of head entry
dec_instruction  output  XLEN  instruction of head entry
occupancy  output  $clog2(DEPTH)+1  entries currently held
fetch_fault  output  1  sticky: fetch stopped on misaligned/out-of-range PC

Behaviour:
- Clock clk; reset rst is synchronous and active-high. Reset: fetch_pc=RESET_PC, state=RUN, queue empty, in-flight cleared; imem_req=0 in reset cycle, dec_valid=0, occupancy=0, fetch_fault=0.
- States: RUN, FAULT. RUN->FAULT when fetch_pc[1:0]!=0 or fetch_pc>=2**ADDR_WIDTH (checked combinationally; no request issued for that PC). FAULT->RUN only on aligned, in-range redirect. fetch_fault=1 iff state==FAULT.
- imem_req = state==RUN && fetch_enable && !redirect_valid && !bad_pc && (occupancy + inflight) < DEPTH. Same-cycle pop is not credited (conservative). imem_addr=fetch_pc always.
- On issue: fetch_pc <= fetch_pc+4 (wraps mod 2**XLEN); inflight<=1, inflight_pc<=fetch_pc. No issue: inflight<=0.
- Response: cycle after issue, if inflight and not killed, push {inflight_pc, imem_rdata} at tail. Credit rule guarantees no overflow; push into a full queue is an assertion failure.
- Latency: request at T -> dec_valid at T+2 (no bypass around queue).
- Pop when dec_valid && dec_ready; head advances, order preserved. Simultaneous push+pop: occupancy unchanged.
- Redirect (highest priority): queue emptied, occupancy<=0, in-flight response arriving this or next cycle discarded, no request this cycle, fetch_pc<=redirect_pc. A pop handshaking in the same cycle counts as consumed. Next cycle issues from redirect_pc (if legal and enabled). Misaligned/out-of-range redirect: flush still happens, then FAULT next cycle.
- fetch_enable=0: no new issue; in-flight response still lands; decode may keep draining. Redirects still honoured.
- Reset mid-operation overrides everything, including in-flight response and redirect.
- Pointer wrap: read/write pointers $clog2(DEPTH) bits, wrap naturally; full/empty from occupancy.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {RUN, FAULT}, INSTR_BYTES=4, fetch_entry_t struct {pc, instruction}.
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, flush, head, count), one instance holding fetch_entry_t. Top holds PC, state, in-flight tracking and credit logic.

Test Plan:
- Reset, fetch_enable=1, dec_ready=1, imem_rdata=addr-derived -> imem_addr 0,4,8,...; dec_valid first at cycle 2, dec_pc 0,4,8 one per cycle, occupancy steady <=2.
- dec_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, occupancy=4, imem_req=0; release -> PCs 0,4,8,12 drain in order, fetch resumes at 16.
- Redirect to 0x100 while occupancy=3 and request in flight -> occupancy 0 next cycle, stale response dropped, next imem_addr=0x100, next dec_pc=0x100.
- Redirect in same cycle as accepted pop -> popped entry consumed once, no duplicates, queue empty after.
- Redirect to 0x102 -> flush, fetch_fault=1, imem_req=0 thereafter; redirect to 0x200 -> fault clears, fetch from 0x200. Sequential fetch reaching 0x10000 with ADDR_WIDTH=16 -> fault, no request at 0x10000.
- rst asserted with full queue and in-flight fetch -> next cycle occupancy=0, dec_valid=0, imem_addr=RESET_PC; toggle fetch_enable=0 -> PC holds, in-flight entry still delivered.
